// File: rtl/jt51_search_pkg.sv
// Shared definitions for the phinc-to-keycode successive-approximation search.
// Holds the default widths, the FSM state encoding and the iteration-counter width.
package jt51_search_pkg;

  localparam int unsigned KCW_DEF = 10;
  localparam int unsigned PHW_DEF = 12;
  localparam int unsigned CNT_W   = $clog2(KCW_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2
  } state_t;

endpackage

// File: rtl/jt51_phinc_search_if.sv
// Request/result bundle of the phinc search block.
//   start_valid/start_ready : request handshake, target sampled on acceptance
//   target                  : requested phase increment
//   done                    : one-cycle pulse, results just updated
//   kc_out/exact/underflow  : search result, held between done pulses
interface jt51_phinc_search_if
  import jt51_search_pkg::*;
#(
  parameter int unsigned KCW = KCW_DEF,
  parameter int unsigned PHW = PHW_DEF
);
  logic           start_valid;
  logic           start_ready;
  logic [PHW-1:0] target;
  logic           done;
  logic [KCW-1:0] kc_out;
  logic           exact;
  logic           underflow;

  modport master (
    output start_valid, target,
    input  start_ready, done, kc_out, exact, underflow
  );

  modport slave (
    input  start_valid, target,
    output start_ready, done, kc_out, exact, underflow
  );
endinterface

// File: rtl/jt51_phinc_search.sv
// Inverse keycode->phinc lookup: finds the largest keycode whose table phinc
// does not exceed the target, one table probe per cycle (MSB first).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request/result interface (slave side)
//   rom_kc     : keycode presented to the external table
//   rom_phinc  : table phinc for rom_kc, combinational same-cycle
module jt51_phinc_search
  import jt51_search_pkg::*;
#(
  parameter int unsigned KCW = KCW_DEF,
  parameter int unsigned PHW = PHW_DEF
)(
  input  logic                 clk,
  input  logic                 rst_n,
  jt51_phinc_search_if.slave   bus,
  output logic [KCW-1:0]       rom_kc,
  input  logic [PHW-1:0]       rom_phinc
);

  localparam int unsigned IW = (KCW > 1) ? $clog2(KCW) : 1;

  state_t         state_q, state_d;
  logic [PHW-1:0] target_q, target_d;
  logic [KCW-1:0] result_q, result_d;
  logic [IW-1:0]  bit_q, bit_d;
  logic [KCW-1:0] rom_kc_q, rom_kc_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic [KCW-1:0] kc_out_q, kc_out_d;
  logic           exact_q, exact_d;
  logic           uf_q, uf_d;

  logic           hit;
  logic           uf;
  logic [KCW-1:0] result_set;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      result_q <= '0;
      bit_q    <= '0;
      rom_kc_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      kc_out_q <= '0;
      exact_q  <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      result_q <= result_d;
      bit_q    <= bit_d;
      rom_kc_q <= rom_kc_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      kc_out_q <= kc_out_d;
      exact_q  <= exact_d;
      uf_q     <= uf_d;
    end
  end

  // Next-state and SAR datapath. rom_kc is computed one cycle ahead so the
  // probe keycode comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    result_d   = result_q;
    bit_d      = bit_q;
    rom_kc_d   = rom_kc_q;
    done_d     = 1'b0;
    kc_out_d   = kc_out_q;
    exact_d    = exact_q;
    uf_d       = uf_q;
    hit        = 1'b0;
    uf         = 1'b0;
    result_set = result_q;

    case (state_q)
      IDLE: begin
        if (bus.start_valid && ready_q) begin
          target_d = bus.target;
          result_d = '0;
          bit_d    = IW'(KCW - 1);
          rom_kc_d = KCW'(1) << (KCW - 1);
          state_d  = SEARCH;
        end
      end

      SEARCH: begin
        hit        = (rom_phinc <= target_q);
        result_set = result_q | (hit ? (KCW'(1) << bit_q) : KCW'(0));
        result_d   = result_set;
        if (bit_q == '0) begin
          rom_kc_d = result_set;
          state_d  = CHECK;
        end else begin
          bit_d    = bit_q - IW'(1);
          rom_kc_d = result_set | (KCW'(1) << (bit_q - IW'(1)));
        end
      end

      CHECK: begin
        // rom_kc == result here, so rom_phinc is phinc(result)
        uf       = (result_q == '0) && (rom_phinc > target_q);
        kc_out_d = uf ? KCW'(0) : result_q;
        exact_d  = !uf && (rom_phinc == target_q);
        uf_d     = uf;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign rom_kc        = rom_kc_q;
  assign bus.start_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.kc_out    = kc_out_q;
  assign bus.exact     = exact_q;
  assign bus.underflow = uf_q;

endmodule

// File: tb/tb_jt51_phinc_search.sv
// Scoreboard bench for jt51_phinc_search: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_jt51_phinc_search;
  localparam int unsigned KCW = 10;
  localparam int unsigned PHW = 12;

  typedef struct {
    int kc;
    int ex;
    int uf;
    int cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [KCW-1:0] rom_kc;
  logic [PHW-1:0] rom_phinc;
  int             table_sel = 0;
  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;
  exp_t           sb[$];

  jt51_phinc_search_if #(.KCW(KCW), .PHW(PHW)) bus ();

  jt51_phinc_search #(.KCW(KCW), .PHW(PHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rom_kc    (rom_kc),
    .rom_phinc (rom_phinc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Table models: 0 = 4k, 1 = 4k+8 (saturated), 2 = 4k with plateau 200 at 48..51
  function automatic logic [PHW-1:0] phinc_of(input logic [KCW-1:0] kc, input int sel);
    int k;
    int v;
    k = int'(kc);
    case (sel)
      1:       v = (4 * k + 8 > 4095) ? 4095 : 4 * k + 8;
      2:       v = (k >= 48 && k <= 51) ? 200 : 4 * k;
      default: v = 4 * k;
    endcase
    return PHW'(v);
  endfunction

  assign rom_phinc = phinc_of(rom_kc, table_sel);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest pending expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("kc_out", 32'(bus.kc_out), 32'(e.kc));
        check("exact", 32'(bus.exact), 32'(e.ex));
        check("underflow", 32'(bus.underflow), 32'(e.uf));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input int tgt, input int kc, input int ex, input int uf, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.start_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.start_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got start_ready=%b, expected 1", bus.start_ready);
      return;
    end
    bus.start_valid = 1'b1;
    bus.target      = PHW'(tgt);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    if (push) sb.push_back('{kc, ex, uf, cyc + 11});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs();
    check("rst_ready", 32'(bus.start_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_kc_out", 32'(bus.kc_out), 32'd0);
    check("rst_exact", 32'(bus.exact), 32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    check("rst_rom_kc", 32'(rom_kc), 32'd0);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.target      = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs();

    // Linear table
    table_sel = 0;
    issue(400, 100, 1, 0, 1'b1);
    drain();
    issue(401, 100, 0, 0, 1'b1);
    issue(403, 100, 0, 0, 1'b1);   // accepted in the done cycle of the previous one
    drain();
    issue(4095, 1023, 0, 0, 1'b1);
    drain();
    issue(4092, 1023, 1, 0, 1'b1);
    drain();

    // Offset table: underflow and exact hit at keycode 0
    table_sel = 1;
    issue(5, 0, 0, 1, 1'b1);
    drain();
    issue(8, 0, 1, 0, 1'b1);
    drain();

    // Plateau: largest tying keycode wins
    table_sel = 2;
    issue(200, 51, 1, 0, 1'b1);
    drain();

    // Reset in the middle of a search discards it
    issue(1234, 0, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs();
    repeat (15) @(negedge clk);

    // New request completes; start_valid during SEARCH is ignored
    issue(1000, 250, 1, 0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.target      = '0;
    repeat (4) @(negedge clk);
    bus.start_valid = 1'b0;
    drain();
    repeat (15) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
